// File: rtl/gray_decoder_pkg.sv
// Shared definitions for the Gray-code tracking decoder: FSM states and
// default parameter values.
package gray_decoder_pkg;

   localparam int DEFAULT_WIDTH = 3;
   localparam int DEFAULT_CNTW  = 8;

   // Tracking FSM: IDLE waits for a baseline, TRACK follows the counter,
   // ERR parks after an illegal transition until cleared.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERR   = 2'd2
   } state_e;

endpackage : gray_decoder_pkg

// File: rtl/gray_decoder_gray2bin.sv
// Combinational Gray-to-binary converter.
// Bit i of the binary result is the XOR of all Gray bits from the MSB down
// to i, which unrolls the b[i] = b[i+1] ^ g[i] recurrence without a
// self-referencing combinational loop.
module gray2bin #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin_o[i] = ^(gray_i >> i);
   end

endmodule : gray2bin

// File: rtl/gray_decoder.sv
// Gray-code tracking decoder: decodes codes sampled from an upstream Gray
// counter, checks that each new code is a hold or a +1 step, counts wraps
// and flags illegal transitions. All outputs are registered.
module gray_decoder
   import gray_decoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNTW  = DEFAULT_CNTW
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] In,
   input  logic             Valid,
   input  logic             Clr,
   output logic [WIDTH-1:0] Binary,
   output logic             BinValid,
   output logic             Overflow,
   output logic [CNTW-1:0]  WrapCnt,
   output logic             Error
);

   state_e            state_q,     state_d;
   logic [WIDTH-1:0]  code_q,      code_d;
   logic [WIDTH-1:0]  binary_q,    binary_d;
   logic              bin_valid_q, bin_valid_d;
   logic              overflow_q,  overflow_d;
   logic [CNTW-1:0]   wrap_cnt_q,  wrap_cnt_d;
   logic              error_q,     error_d;

   logic [WIDTH-1:0]  in_bin;
   logic [WIDTH-1:0]  bin_inc;
   logic              is_hold;
   logic              is_step;

   gray2bin #(
      .WIDTH (WIDTH)
   ) u_gray2bin (
      .gray_i (In),
      .bin_o  (in_bin)
   );

   // A hold compares raw codes against the stored code so it is bit-exact;
   // a step compares the decoded value against last Binary + 1 (mod 2^WIDTH).
   assign bin_inc = binary_q + WIDTH'(1);
   assign is_hold = (In == code_q);
   assign is_step = (in_bin == bin_inc);

   // Next-state and next-output logic for the tracking FSM.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      code_d      = code_q;
      binary_d    = binary_q;
      bin_valid_d = 1'b0;
      overflow_d  = overflow_q;
      wrap_cnt_d  = wrap_cnt_q;
      error_d     = error_q;

      if (Clr) begin
         // Clear beats a coincident Valid; the sampled code is dropped.
         state_d    = ST_IDLE;
         code_d     = '0;
         binary_d   = '0;
         overflow_d = 1'b0;
         wrap_cnt_d = '0;
         error_d    = 1'b0;
      end else if (Valid) begin
         unique case (state_q)
            ST_IDLE: begin
               code_d      = In;
               binary_d    = in_bin;
               bin_valid_d = 1'b1;
               state_d     = ST_TRACK;
            end
            ST_TRACK: begin
               if (is_hold) begin
                  // Counter has not moved: nothing to report.
               end else if (is_step) begin
                  code_d      = In;
                  binary_d    = in_bin;
                  bin_valid_d = 1'b1;
                  if (binary_q == '1) begin
                     overflow_d = 1'b1;
                     if (wrap_cnt_q != '1) begin
                        wrap_cnt_d = wrap_cnt_q + CNTW'(1);
                     end
                  end
               end else begin
                  error_d = 1'b1;
                  state_d = ST_ERR;
               end
            end
            ST_ERR: begin
               // Parked until Clr or reset.
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         code_q      <= '0;
         binary_q    <= '0;
         bin_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         wrap_cnt_q  <= '0;
         error_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q     <= state_d;
         code_q      <= code_d;
         binary_q    <= binary_d;
         bin_valid_q <= bin_valid_d;
         overflow_q  <= overflow_d;
         wrap_cnt_q  <= wrap_cnt_d;
         error_q     <= error_d;
      end
   end

   assign Binary   = binary_q;
   assign BinValid = bin_valid_q;
   assign Overflow = overflow_q;
   assign WrapCnt  = wrap_cnt_q;
   assign Error    = error_q;

endmodule : gray_decoder

// File: tb/tb_gray_decoder.sv
// Directed, table-driven bench for gray_decoder at WIDTH=3, CNTW=8.
module tb_gray_decoder;

   localparam int WIDTH = 3;
   localparam int CNTW  = 8;

   logic             Clk;
   logic             Reset;
   logic [WIDTH-1:0] In;
   logic             Valid;
   logic             Clr;
   logic [WIDTH-1:0] Binary;
   logic             BinValid;
   logic             Overflow;
   logic [CNTW-1:0]  WrapCnt;
   logic             Error;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic             valid;
      logic             clr;
      logic [WIDTH-1:0] code;
      logic [WIDTH-1:0] exp_bin;
      logic             exp_bv;
      logic             exp_ov;
      logic [CNTW-1:0]  exp_wc;
      logic             exp_err;
   } vec_t;

   vec_t vecs[12];

   gray_decoder #(
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .In       (In),
      .Valid    (Valid),
      .Clr      (Clr),
      .Binary   (Binary),
      .BinValid (BinValid),
      .Overflow (Overflow),
      .WrapCnt  (WrapCnt),
      .Error    (Error)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_out(input string name, input logic [WIDTH-1:0] b, input logic bv,
                             input logic ov, input logic [CNTW-1:0] wc, input logic err);
      check({name, ".Binary"},   32'(Binary),   32'(b));
      check({name, ".BinValid"}, 32'(BinValid), 32'(bv));
      check({name, ".Overflow"}, 32'(Overflow), 32'(ov));
      check({name, ".WrapCnt"},  32'(WrapCnt),  32'(wc));
      check({name, ".Error"},    32'(Error),    32'(err));
   endtask

   // Drive one cycle of inputs at the falling edge, sample 1 time unit
   // after the following rising edge.
   task automatic apply(input logic v, input logic c, input logic [WIDTH-1:0] g);
      @(negedge Clk);
      Valid = v;
      Clr   = c;
      In    = g;
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] to_gray(input int b);
      logic [WIDTH-1:0] bb;
      bb = WIDTH'(b);
      return bb ^ (bb >> 1);
   endfunction

   initial begin
      // Full first cycle plus wrap, then a hold and another step.
      vecs[0]  = '{1'b1, 1'b0, 3'b000, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 3'b001, 3'd1, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 3'b011, 3'd2, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 3'b010, 3'd3, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 3'b110, 3'd4, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 3'b111, 3'd5, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 3'b101, 3'd6, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 3'b100, 3'd7, 1'b1, 1'b0, 8'd0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 3'b000, 3'd0, 1'b1, 1'b1, 8'd1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 3'b011, 3'd0, 1'b0, 1'b1, 8'd1, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 3'b000, 3'd0, 1'b0, 1'b1, 8'd1, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 3'b001, 3'd1, 1'b1, 1'b1, 8'd1, 1'b0};

      Reset = 1'b0;
      Valid = 1'b0;
      Clr   = 1'b0;
      In    = '0;
      repeat (3) @(posedge Clk);
      #1;
      expect_out("reset", 3'd0, 1'b0, 1'b0, 8'd0, 1'b0);
      @(negedge Clk);
      Reset = 1'b1;

      // Baseline, eight steps, first wrap, idle, hold, step.
      for (int i = 0; i < 12; i++) begin
         apply(vecs[i].valid, vecs[i].clr, vecs[i].code);
         expect_out($sformatf("vec%0d", i), vecs[i].exp_bin, vecs[i].exp_bv,
                    vecs[i].exp_ov, vecs[i].exp_wc, vecs[i].exp_err);
      end

      // Three more full cycles from Binary=1: wraps land at 2, 3, 4.
      for (int k = 2; k < 2 + 8 * 3; k++) apply(1'b1, 1'b0, to_gray(k % 8));
      expect_out("wrap4", 3'd1, 1'b1, 1'b1, 8'd4, 1'b0);

      // Two-bit change from 011 goes to ERR; later codes are ignored.
      apply(1'b0, 1'b1, 3'b000);
      expect_out("clr1", 3'd0, 1'b0, 1'b0, 8'd0, 1'b0);
      apply(1'b1, 1'b0, 3'b000);
      apply(1'b1, 1'b0, 3'b001);
      apply(1'b1, 1'b0, 3'b011);
      expect_out("pre_err", 3'd2, 1'b1, 1'b0, 8'd0, 1'b0);
      apply(1'b1, 1'b0, 3'b110);
      expect_out("multibit_err", 3'd2, 1'b0, 1'b0, 8'd0, 1'b1);
      apply(1'b1, 1'b0, 3'b010);
      expect_out("err_ignore", 3'd2, 1'b0, 1'b0, 8'd0, 1'b1);

      // Backward step 011 -> 001 is also illegal.
      apply(1'b0, 1'b1, 3'b000);
      apply(1'b1, 1'b0, 3'b011);
      expect_out("baseline_011", 3'd2, 1'b1, 1'b0, 8'd0, 1'b0);
      apply(1'b1, 1'b0, 3'b001);
      expect_out("backward_err", 3'd2, 1'b0, 1'b0, 8'd0, 1'b1);

      // Repeated code gives one BinValid, then idle cycles hold everything.
      apply(1'b0, 1'b1, 3'b000);
      apply(1'b1, 1'b0, 3'b001);
      expect_out("hold_first", 3'd1, 1'b1, 1'b0, 8'd0, 1'b0);
      apply(1'b1, 1'b0, 3'b001);
      expect_out("hold_repeat", 3'd1, 1'b0, 1'b0, 8'd0, 1'b0);
      begin
         int pulses = 0;
         for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 3'b111);
            if (BinValid) pulses++;
         end
         check("idle_pulses", 32'(pulses), 32'd0);
      end
      expect_out("hold_idle", 3'd1, 1'b0, 1'b0, 8'd0, 1'b0);

      // 256 wraps saturate WrapCnt at 255.
      apply(1'b0, 1'b1, 3'b000);
      apply(1'b1, 1'b0, 3'b000);
      for (int w = 0; w < 256; w++) begin
         for (int k = 1; k <= 8; k++) apply(1'b1, 1'b0, to_gray(k % 8));
         if (w == 254) expect_out("wrap255", 3'd0, 1'b1, 1'b1, 8'd255, 1'b0);
      end
      expect_out("wrap_sat", 3'd0, 1'b1, 1'b1, 8'd255, 1'b0);

      // Clr and Valid together: Clr wins and the code is discarded.
      apply(1'b1, 1'b1, 3'b001);
      expect_out("clr_wins", 3'd0, 1'b0, 1'b0, 8'd0, 1'b0);
      // Back in IDLE: a non-adjacent code is accepted as a fresh baseline.
      apply(1'b1, 1'b0, 3'b101);
      expect_out("idle_after_clr", 3'd6, 1'b1, 1'b0, 8'd0, 1'b0);

      // Reset asserted between edges mid-stream clears outputs at once.
      apply(1'b0, 1'b1, 3'b000);
      apply(1'b1, 1'b0, 3'b000);
      apply(1'b1, 1'b0, 3'b001);
      apply(1'b1, 1'b0, 3'b011);
      expect_out("pre_reset", 3'd2, 1'b1, 1'b0, 8'd0, 1'b0);
      #2;
      Reset = 1'b0;
      #1;
      expect_out("async_reset", 3'd0, 1'b0, 1'b0, 8'd0, 1'b0);
      @(posedge Clk);
      #2;
      Reset = 1'b1;
      apply(1'b1, 1'b0, 3'b101);
      expect_out("rebaseline", 3'd6, 1'b1, 1'b0, 8'd0, 1'b0);
      apply(1'b1, 1'b0, 3'b100);
      expect_out("step_after_rst", 3'd7, 1'b1, 1'b0, 8'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_gray_decoder
